// File: rtl/user_switch_event_ctrl.sv
// Switch event controller: debounced levels -> press/release(/long) events, arbitrated into a FIFO.
// Long-press detection (hold counters, kind 2'b11) is built only when USER_SWITCH_LONG_PRESS_EN is defined.

module user_switch_event_lane #(
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd25_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       switch_state,
    input  logic [2:0] grant,      // {release, long, press}
    output logic       level,
    output logic [2:0] pending,    // {release, long, press}
    output logic       drop
);
    logic [2:0] fire;

    assign fire[0] = switch_state & ~level;
    assign fire[2] = ~switch_state & level;

`ifdef USER_SWITCH_LONG_PRESS_EN
    logic [31:0] hold_count;

    always_ff @(posedge clock) begin
        if (!reset_n)
            hold_count <= '0;
        else if (fire[0])
            hold_count <= '0;
        else if (switch_state && hold_count != LONG_PRESS_CYCLES)
            hold_count <= hold_count + 32'd1;
    end

    // Fires only on the step into the saturation value, so once per press.
    assign fire[1] = switch_state & ~fire[0] & (hold_count != LONG_PRESS_CYCLES)
                   & (hold_count + 32'd1 == LONG_PRESS_CYCLES);
`else
    // Parameter still referenced so both builds share one parameter list.
    assign fire[1] = (LONG_PRESS_CYCLES == 32'd0) & 1'b0;
`endif

    // A bit granted this cycle is free again, so only a still-held bit drops a recurrence.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level   <= 1'b0;
            pending <= '0;
        end else begin
            level   <= switch_state;
            pending <= fire | (pending & ~grant);
        end
    end

    assign drop = |(fire & pending & ~grant);
endmodule

module user_switch_event_ctrl #(
    parameter int          NUM_SWITCHES       = 4,
    parameter int          SWITCH_INDEX_WIDTH = 2,
    parameter logic [31:0] LONG_PRESS_CYCLES  = 32'd25_000_000,
    parameter int          FIFO_DEPTH         = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_SWITCHES-1:0]         switch_state,
    output logic                            event_valid,
    input  logic                            event_ready,
    output logic [1:0]                      event_kind,
    output logic [SWITCH_INDEX_WIDTH-1:0]   event_switch,
    output logic [NUM_SWITCHES-1:0]         switch_level,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clear
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0]                    kind;
        logic [SWITCH_INDEX_WIDTH-1:0] sw;
    } event_t;

    logic [NUM_SWITCHES-1:0][2:0] pending;
    logic [NUM_SWITCHES-1:0][2:0] grant;
    logic [NUM_SWITCHES-1:0]      drop;

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_lane
        user_switch_event_lane #(.LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)) u_lane (
            .clock        (clock),
            .reset_n      (reset_n),
            .switch_state (switch_state[i]),
            .grant        (grant[i]),
            .level        (switch_level[i]),
            .pending      (pending[i]),
            .drop         (drop[i])
        );
    end

    // Scan from the lowest-priority request upward; the last hit wins.
    logic   push;
    event_t push_ev;

    always_comb begin
        grant   = '0;
        push    = 1'b0;
        push_ev = '0;
        if (fifo_count < CW'(FIFO_DEPTH)) begin
            for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
                for (int k = 2; k >= 0; k--) begin
                    if (pending[i][k]) begin
                        grant       = '0;
                        grant[i][k] = 1'b1;
                        push        = 1'b1;
                        push_ev.sw  = SWITCH_INDEX_WIDTH'(i);
                        case (k)
                            0:       push_ev.kind = 2'b01;
                            1:       push_ev.kind = 2'b11;
                            default: push_ev.kind = 2'b10;
                        endcase
                    end
                end
            end
        end
    end

    event_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop;

    assign event_valid  = fifo_count != '0;
    assign pop          = event_valid & event_ready;
    assign event_kind   = event_valid ? mem[rd_ptr].kind : 2'b00;
    assign event_switch = event_valid ? mem[rd_ptr].sw : '0;

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_ev;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            overflow   <= (|drop) | (overflow & ~overflow_clear);
        end
    end
endmodule

// File: tb/tb_user_switch_event_ctrl.sv
// Bench for user_switch_event_ctrl: directed scenarios plus random switch/ready traffic checked
// every cycle against a queue-based event model (honours USER_SWITCH_LONG_PRESS_EN).

module tb_user_switch_event_ctrl;
    localparam int NS    = 4;
    localparam int DEPTH = 4;
    localparam int LP    = 100;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NS-1:0] switch_state;
    logic          event_valid;
    logic          event_ready;
    logic [1:0]    event_kind;
    logic [1:0]    event_switch;
    logic [NS-1:0] switch_level;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          overflow_clear;

    user_switch_event_ctrl #(
        .NUM_SWITCHES(NS), .SWITCH_INDEX_WIDTH(2),
        .LONG_PRESS_CYCLES(32'(LP)), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .switch_state   (switch_state),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_kind     (event_kind),
        .event_switch   (event_switch),
        .switch_level   (switch_level),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int n_long_seen = 0;

    // Reference model: events as kind*256+switch in a queue, pending flags per switch/kind.
    int q[$];
    bit pend [NS][3];   // [press, long, release]
    bit prev [NS];
    int hold [NS];
    bit ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  kc [3] = '{1, 3, 2};
        bit  can_push, do_pop, found, drop, st;
        bit  ev [3];
        int  ent;
        if (!reset_n) begin
            q.delete();
            for (int s = 0; s < NS; s++) begin
                prev[s] = 0; hold[s] = 0;
                for (int k = 0; k < 3; k++) pend[s][k] = 0;
            end
            ovf = 0;
            return;
        end
        can_push = q.size() < DEPTH;
        do_pop   = q.size() != 0 && event_ready;
        found    = 0;
        ent      = 0;
        if (can_push) begin
            for (int s = 0; s < NS; s++)
                for (int k = 0; k < 3; k++)
                    if (!found && pend[s][k]) begin
                        found = 1; pend[s][k] = 0; ent = kc[k] * 256 + s;
                    end
        end
        if (do_pop) void'(q.pop_front());
        if (found) q.push_back(ent);
        drop = 0;
        for (int s = 0; s < NS; s++) begin
            st    = switch_state[s];
            ev[0] = st && !prev[s];
            ev[1] = 0;
            ev[2] = !st && prev[s];
`ifdef USER_SWITCH_LONG_PRESS_EN
            if (ev[0]) hold[s] = 0;
            else if (st && hold[s] < LP) begin
                hold[s]++;
                if (hold[s] == LP) ev[1] = 1;
            end
`endif
            for (int k = 0; k < 3; k++)
                if (ev[k]) begin
                    if (pend[s][k]) drop = 1;
                    else pend[s][k] = 1;
                end
            prev[s] = st;
        end
        ovf = drop ? 1'b1 : (overflow_clear ? 1'b0 : ovf);
    endtask

    task automatic check_model();
        logic [31:0] ek, es, lvl;
        ek = (q.size() != 0) ? 32'(q[0] / 256) : 32'd0;
        es = (q.size() != 0) ? 32'(q[0] % 256) : 32'd0;
        lvl = '0;
        for (int s = 0; s < NS; s++) lvl[s] = prev[s];
        chk("event_valid", 32'(event_valid), 32'(q.size() != 0));
        chk("event_kind", 32'(event_kind), ek);
        chk("event_switch", 32'(event_switch), es);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("switch_level", 32'(switch_level), lvl);
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            check_model();
            if (event_valid === 1'b1 && event_ready && event_kind === 2'b11) n_long_seen++;
        end
    endtask

    initial begin
        reset_n = 0; switch_state = 4'b0100; event_ready = 1; overflow_clear = 0;
        cycle(2);
        chk("reset_valid", 32'(event_valid), 32'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);

        // Switch 2 held through reset -> press after reset, 2-cycle latency.
        reset_n = 1;
        cycle();
        chk("lat1_valid", 32'(event_valid), 32'd0);
        cycle();
        chk("lat2_valid", 32'(event_valid), 32'd1);
        chk("lat2_kind", 32'(event_kind), 32'd1);
        chk("lat2_switch", 32'(event_switch), 32'd2);
        cycle(9);
        switch_state = 4'b0000;
        cycle(4);
        chk("single_drained", 32'(fifo_count), 32'd0);

        // Simultaneous edges.
        switch_state = 4'b1011; cycle(6);
        switch_state = 4'b0000; cycle(6);

        // Backpressure: 6 events, FIFO holds 4.
        event_ready = 0;
        switch_state = 4'b1111; cycle();
        switch_state = 4'b0011; cycle(6);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        event_ready = 1; cycle(8);
        switch_state = 4'b0000; cycle(4);
        chk("full_drained", 32'(fifo_count), 32'd0);

        // Overflow: fill, then double-toggle switch 1.
        event_ready = 0;
        switch_state = 4'b1101; cycle();
        switch_state = 4'b0000; cycle(3);
        switch_state = 4'b0010; cycle();
        switch_state = 4'b0000; cycle();
        switch_state = 4'b0010; cycle(2);
        chk("ovf_set", 32'(overflow), 32'd1);
        overflow_clear = 1; cycle();
        overflow_clear = 0; cycle();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        overflow_clear = 1; switch_state = 4'b0000; cycle();
        overflow_clear = 0; cycle();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        event_ready = 1; cycle(12);
        overflow_clear = 1; cycle();
        overflow_clear = 0; cycle();

        // Long press: 150-cycle hold, then 99-cycle hold.
        n_long_seen = 0;
        switch_state = 4'b0001; cycle(150);
        switch_state = 4'b0000; cycle(5);
`ifdef USER_SWITCH_LONG_PRESS_EN
        chk("long_150", 32'(n_long_seen), 32'd1);
`else
        chk("long_150", 32'(n_long_seen), 32'd0);
`endif
        n_long_seen = 0;
        switch_state = 4'b0001; cycle(99);
        switch_state = 4'b0000; cycle(5);
        chk("long_99", 32'(n_long_seen), 32'd0);

        // Reset with events queued.
        event_ready = 0;
        switch_state = 4'b0111; cycle(5);
        reset_n = 0; cycle();
        chk("rst_mid_valid", 32'(event_valid), 32'd0);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_ovf", 32'(overflow), 32'd0);
        reset_n = 1; event_ready = 1; cycle(8);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            for (int s = 0; s < NS; s++)
                if ($urandom_range(7) == 0) switch_state[s] = ~switch_state[s];
            event_ready    = $urandom_range(2) != 0;
            overflow_clear = $urandom_range(15) == 0;
            reset_n        = $urandom_range(499) != 0;
            cycle();
        end
        reset_n = 1; overflow_clear = 0; event_ready = 1; switch_state = '0;
        cycle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
